// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment counter path.
// Holds the digit width and the load-value clamp helper.
// Pure declarations; no logic, no latency, no flow control.
package seg_pkg;

  localparam int unsigned DIGIT_W = 4;

  // Force an out-of-range digit to the largest legal value for the modulus.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] value,
                                                     input int unsigned mod);
    if (32'(value) >= mod) begin
      return DIGIT_W'(mod - 1);
    end
    return value;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// Single modulo-MOD digit register with clear, clamped load and up/down step.
// One cycle: the new digit value is visible after the clock edge.
// No backpressure; step is decided by the parent's carry/borrow chain.
module bcd_digit
  import seg_pkg::*;
#(
  parameter int unsigned MOD = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               step,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               at_max,
  output logic               at_min
);

  localparam logic [DIGIT_W-1:0] MaxV = DIGIT_W'(MOD - 1);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  assign q      = q_q;
  assign at_max = (q_q == MaxV);
  assign at_min = (q_q == '0);

  // Next digit value: clear beats load beats step; wraps compare against MOD-1.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = clamp_digit(ld_val, MOD);
    end else if (step) begin
      if (up) begin
        q_d = at_max ? '0 : q_q + 4'd1;
      end else begin
        q_d = at_min ? MaxV : q_q - 4'd1;
      end
    end
  end

  // Digit register with asynchronous clear to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit modulo-MOD up/down counter with load, clear, terminal-count and zero flags.
// One cycle: data/tc/zero reflect the enabled edge immediately; the carry chain is combinational.
// No backpressure; every enabled edge advances the count by exactly one step.
module bcd_updown_counter
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned MOD    = 10,
  parameter int unsigned DW     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGITS*DW-1:0] load_val,
  input  logic               up,
  output logic [DIGITS*DW-1:0] data,
  output logic               tc,
  output logic               zero
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  // chain[k] is high when every digit below k sits at its wrap point for the current direction.
  logic [DIGITS:0]   chain;

  logic tc_q, tc_d;
  logic zero_q, zero_d;
  logic hi_zero;

  assign chain[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign chain[k+1] = chain[k] & (up ? at_max[k] : at_min[k]);
    assign step[k]    = en & chain[k];

    bcd_digit #(.MOD(MOD)) u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .load   (load),
      .ld_val (load_val[k*DW +: DW]),
      .step   (step[k]),
      .up     (up),
      .q      (data[k*DW +: DW]),
      .at_max (at_max[k]),
      .at_min (at_min[k])
    );
  end

  // Terminal count and next-state zero flag, derived without re-running the digit math.
  always_comb begin
    tc_d    = 1'b0;
    zero_d  = zero_q;
    hi_zero = 1'b1;
    for (int k = 1; k < DIGITS; k++) begin
      hi_zero = hi_zero & at_min[k];
    end
    if (clr) begin
      zero_d = 1'b1;
    end else if (load) begin
      // Clamping never maps a nonzero digit to zero, so the raw value decides.
      zero_d = (load_val == '0);
    end else if (en) begin
      tc_d = chain[DIGITS];
      if (up) begin
        zero_d = chain[DIGITS];
      end else begin
        zero_d = hi_zero & (data[DW-1:0] == 4'd1);
      end
    end
  end

  // Flag registers; zero comes up set since reset clears every digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q   <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      tc_q   <= tc_d;
      zero_q <= zero_d;
    end
  end

  assign tc   = tc_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: two-digit MOD=10 and MOD=16 instances on shared inputs.
// Expected values come from an integer model of the whole count (value mod MOD^2).
// Directed scenarios followed by a randomized run.
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, clr = 1'b0, load = 1'b0, up = 1'b1;
  logic [7:0] load_val = 8'h00;
  logic [7:0] data_a, data_b;
  logic       tc_a, tc_b, zero_a, zero_b;

  int errors = 0;
  int checks = 0;

  // Model state: whole count as an integer per instance.
  int mv[2];
  int mt[2];
  int mods[2] = '{10, 16};

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .MOD(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .up(up), .data(data_a), .tc(tc_a), .zero(zero_a)
  );

  bcd_updown_counter #(.DIGITS(2), .MOD(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .up(up), .data(data_b), .tc(tc_b), .zero(zero_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] packed_val(input int v, input int m);
    logic [7:0] r;
    r[3:0] = 4'(v % m);
    r[7:4] = 4'(v / m);
    return r;
  endfunction

  function automatic int clamp(input int d, input int m);
    return (d >= m) ? m - 1 : d;
  endfunction

  // Apply the counting rules for one clock edge to both model instances.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int m = mods[i];
      int total = m * m;
      mt[i] = 0;
      if (clr) begin
        mv[i] = 0;
      end else if (load) begin
        mv[i] = clamp(int'(load_val[7:4]), m) * m + clamp(int'(load_val[3:0]), m);
      end else if (en) begin
        if (up) begin
          mt[i] = (mv[i] == total - 1) ? 1 : 0;
          mv[i] = (mv[i] + 1) % total;
        end else begin
          mt[i] = (mv[i] == 0) ? 1 : 0;
          mv[i] = (mv[i] + total - 1) % total;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " data10"}, data_a, packed_val(mv[0], 10));
    check({tag, " tc10"},   {7'd0, tc_a}, 8'(mt[0]));
    check({tag, " zero10"}, {7'd0, zero_a}, {7'd0, mv[0] == 0});
    check({tag, " data16"}, data_b, packed_val(mv[1], 16));
    check({tag, " tc16"},   {7'd0, tc_b}, 8'(mt[1]));
    check({tag, " zero16"}, {7'd0, zero_b}, {7'd0, mv[1] == 0});
  endtask

  // One clock edge with the currently driven inputs, then compare.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic e, input logic c, input logic l, input logic u,
                        input logic [7:0] lv);
    en = e; clr = c; load = l; up = u; load_val = lv;
  endtask

  initial begin
    mv = '{0, 0};
    mt = '{0, 0};
    #12;
    check_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all("post_reset_idle");

    // Reset mid-count
    set_in(0, 0, 1, 1, 8'h36); tick("load36");
    set_in(1, 0, 0, 1, 8'h00); tick("to37");
    #2 rst_n = 1'b0;
    mv = '{0, 0}; mt = '{0, 0};
    #1 check_all("async_reset");
    #2 rst_n = 1'b1;
    tick("release_step1");
    tick("release_step2");

    // Up wrap
    set_in(0, 0, 1, 1, 8'h98); tick("load98");
    set_in(1, 0, 0, 1, 8'h00);
    tick("up99");
    tick("up_wrap");
    tick("up_after_wrap");

    // Down borrow
    set_in(0, 0, 1, 0, 8'h10); tick("load10");
    set_in(1, 0, 0, 0, 8'h00);
    tick("down09");
    tick("down08");
    set_in(0, 0, 1, 0, 8'h00); tick("load00");
    set_in(1, 0, 0, 0, 8'h00); tick("down_wrap");
    tick("down_after_wrap");
    set_in(0, 0, 1, 0, 8'h01); tick("load01");
    set_in(1, 0, 0, 0, 8'h00); tick("down_to_zero");

    // Priority
    set_in(0, 0, 1, 1, 8'h45); tick("load45");
    set_in(1, 1, 1, 1, 8'h27); tick("clr_wins");
    set_in(1, 0, 1, 1, 8'h27); tick("load_over_en");

    // Load clamp and hex wrap
    set_in(0, 0, 1, 1, 8'hAF); tick("clamp_AF");
    set_in(0, 0, 1, 1, 8'hFE); tick("loadFE");
    set_in(1, 0, 0, 1, 8'h00);
    tick("upFF");
    tick("hex_wrap");

    // Hold while toggling direction
    set_in(0, 0, 1, 1, 8'h53); tick("load53");
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, i[0], 8'h00);
      tick("hold");
    end

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      int r = int'($urandom_range(0, 99));
      set_in(r < 80, r >= 97, (r >= 90) && (r < 97), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
